// File: rtl/victim_sel.sv
// victim_sel: picks a cache way to replace on a miss. Prefers the lowest
// invalid, unlocked way; otherwise rotates from a pseudo-random start taken
// from the shared LFSR (advanced only when its value is actually consumed).
//
// Handshake: a request transfers on the rising edge where req_valid and
// req_ready are both 1; req_ready is high exactly while the block is idle.
// victim_valid stays high, with victim_way/victim_onehot frozen, until
// fill_done or abort.
module victim_sel #(
  parameter int WAYS       = 4,
  parameter int LFSR_WIDTH = 8,
  parameter int IDXW       = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [LFSR_WIDTH-1:0] lfsr_out,
  output logic                  lfsr_en,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [WAYS-1:0]       way_valid,
  input  logic [WAYS-1:0]       way_lock,
  input  logic                  abort,
  input  logic                  fill_done,
  output logic                  victim_valid,
  output logic [IDXW-1:0]       victim_way,
  output logic [WAYS-1:0]       victim_onehot,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PICK = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [WAYS-1:0] vmask_q, vmask_d;
  logic            victim_valid_q, victim_valid_d;
  logic [IDXW-1:0] victim_way_q, victim_way_d;
  logic [WAYS-1:0] victim_onehot_q, victim_onehot_d;

  logic [WAYS-1:0] eligible;
  logic [WAYS-1:0] free_ways;
  logic [IDXW-1:0] low_idx;
  logic [IDXW-1:0] rnd_idx;
  logic [IDXW-1:0] sel_idx;
  logic            use_rnd;

  // Only the low IDXW bits of the LFSR matter; the rest is deliberately ignored.
  logic unused_lfsr_bits;
  assign unused_lfsr_bits = ^lfsr_out;

  // Candidate victims: lowest free way, and first eligible way rotating from r.
  always_comb begin
    int r_int;
    int pos;
    logic [IDXW-1:0] pos_w;
    eligible  = ~way_lock;
    free_ways = ~vmask_q & eligible;
    low_idx   = '0;
    rnd_idx   = '0;
    r_int     = 0;
    pos       = 0;
    pos_w     = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (free_ways[IDXW'(i)]) low_idx = IDXW'(i);
    end
    if (WAYS > 1) r_int = int'(lfsr_out[IDXW-1:0]);
    // Scan downward so the lowest rotation offset wins.
    for (int k = WAYS - 1; k >= 0; k--) begin
      pos   = (r_int + k) % WAYS;
      pos_w = IDXW'(pos);
      if (eligible[pos_w]) rnd_idx = pos_w;
    end
    use_rnd = (free_ways == '0);
    sel_idx = use_rnd ? rnd_idx : low_idx;
  end

  // Next-state, selection registration and LFSR advance request.
  always_comb begin
    state_d         = state_q;
    vmask_d         = vmask_q;
    victim_valid_d  = victim_valid_q;
    victim_way_d    = victim_way_q;
    victim_onehot_d = victim_onehot_q;
    lfsr_en         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          vmask_d = way_valid;
          state_d = S_PICK;
        end
      end
      S_PICK: begin
        if (abort) begin
          victim_valid_d = 1'b0;
          state_d        = S_IDLE;
        end else if (eligible != '0) begin
          lfsr_en         = use_rnd;
          victim_way_d    = sel_idx;
          victim_onehot_d = WAYS'(1) << sel_idx;
          victim_valid_d  = 1'b1;
          state_d         = S_HOLD;
        end
      end
      S_HOLD: begin
        if (abort || fill_done) begin
          victim_valid_d = 1'b0;
          state_d        = S_IDLE;
        end
      end
      default: begin
        victim_valid_d = 1'b0;
        state_d        = S_IDLE;
      end
    endcase
  end

  // State and selection registers; an async reset drops any selection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= S_IDLE;
      vmask_q         <= '0;
      victim_valid_q  <= 1'b0;
      victim_way_q    <= '0;
      victim_onehot_q <= '0;
    end else begin
      state_q         <= state_d;
      vmask_q         <= vmask_d;
      victim_valid_q  <= victim_valid_d;
      victim_way_q    <= victim_way_d;
      victim_onehot_q <= victim_onehot_d;
    end
  end

  assign req_ready     = (state_q == S_IDLE);
  assign victim_valid  = victim_valid_q;
  assign victim_way    = victim_way_q;
  assign victim_onehot = victim_onehot_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_victim_sel.sv
// Testbench for victim_sel (WAYS=4, LFSR_WIDTH=8).
module tb_victim_sel;

  logic       clk;
  logic       reset;
  logic [7:0] lfsr_out;
  logic       lfsr_en;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] way_valid;
  logic [3:0] way_lock;
  logic       abort;
  logic       fill_done;
  logic       victim_valid;
  logic [1:0] victim_way;
  logic [3:0] victim_onehot;
  logic [1:0] state_dbg;

  int total = 0;
  int bad = 0;
  int exp_en_cnt = 0;
  int en_seen = 0;
  logic [1:0] exp_q[$];

  victim_sel #(.WAYS(4), .LFSR_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .lfsr_out(lfsr_out), .lfsr_en(lfsr_en),
    .req_valid(req_valid), .req_ready(req_ready), .way_valid(way_valid),
    .way_lock(way_lock), .abort(abort), .fill_done(fill_done),
    .victim_valid(victim_valid), .victim_way(victim_way),
    .victim_onehot(victim_onehot), .state_dbg(state_dbg)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: act=%0d exp=%0d @%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit bit_at(input logic [3:0] v, input int n);
    logic [3:0] t;
    t = v >> n;
    return t[0];
  endfunction

  // Reference: lowest invalid unlocked way, else rotate upward from lfsr%4.
  function automatic int ref_pick(input logic [3:0] vm, input logic [3:0] lk,
                                  input logic [7:0] lf, output bit rnd);
    int start;
    int j;
    rnd = 1'b0;
    for (int i = 0; i < 4; i++)
      if (!bit_at(vm, i) && !bit_at(lk, i)) return i;
    rnd = 1'b1;
    start = int'(lf) % 4;
    for (int k = 0; k < 4; k++) begin
      j = (start + k) % 4;
      if (!bit_at(lk, j)) return j;
    end
    return 0;
  endfunction

  // Monitor: pop expected victim on each rising victim_valid; count lfsr_en.
  initial begin
    logic prev;
    logic [1:0] e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (lfsr_en) en_seen++;
      if (victim_valid && !prev) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "sb_unexpected_victim", int'(victim_way), -1);
        end else begin
          e = exp_q.pop_front();
          chk(victim_way == e, "sb_way", int'(victim_way), int'(e));
          chk(victim_onehot == (4'b0001 << e), "sb_onehot", int'(victim_onehot),
              int'(4'b0001 << e));
        end
      end
      prev = victim_valid;
    end
  end

  // Issue one miss; returns in HOLD, #1 after a rising edge.
  task automatic do_miss(input logic [3:0] vm, input logic [3:0] lock1,
                         input logic [3:0] lock2, input logic [7:0] lf, input int stall);
    bit rnd;
    int exp_way;
    int n;
    req_valid = 1'b1;
    way_valid = vm;
    way_lock  = (stall > 0) ? lock1 : lock2;
    lfsr_out  = lf;
    #1;
    chk(req_ready == 1'b1, "ready_before_accept", int'(req_ready), 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    way_valid = 4'($urandom_range(0, 15));
    exp_way = ref_pick(vm, lock2, lf, rnd);
    exp_q.push_back(2'(exp_way));
    if (rnd) exp_en_cnt++;
    for (int c = 0; c < stall; c++) begin
      chk(lfsr_en == 1'b0, "stall_lfsr_en", int'(lfsr_en), 0);
      chk(victim_valid == 1'b0, "stall_valid", int'(victim_valid), 0);
      @(posedge clk); #1;
    end
    way_lock = lock2;
    #1;
    chk(lfsr_en == rnd, "pick_lfsr_en", int'(lfsr_en), int'(rnd));
    n = 0;
    while (!victim_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk(n == 1, "pick_latency", n, 1);
    for (int h = 0; h < 2; h++) begin
      way_lock  = 4'($urandom_range(0, 15));
      lfsr_out  = 8'($urandom_range(0, 255));
      req_valid = 1'b1;
      @(posedge clk); #1;
      chk(victim_valid == 1'b1, "hold_valid", int'(victim_valid), 1);
      chk(victim_way == 2'(exp_way), "hold_way", int'(victim_way), exp_way);
      chk(lfsr_en == 1'b0, "hold_lfsr_en", int'(lfsr_en), 0);
    end
    req_valid = 1'b0;
  endtask

  task automatic finish_fill(input bit ab);
    fill_done = 1'b1;
    abort     = ab;
    @(posedge clk); #1;
    fill_done = 1'b0;
    abort     = 1'b0;
    chk(victim_valid == 1'b0, "release_valid", int'(victim_valid), 0);
    chk(req_ready == 1'b1, "release_ready", int'(req_ready), 1);
  endtask

  // Driver: directed cases, then randomized misses.
  initial begin
    logic [3:0] vm, lk, clr;
    logic [7:0] lf;
    int st;
    reset = 1'b0; lfsr_out = '0; req_valid = 1'b0; way_valid = '0;
    way_lock = '0; abort = 1'b0; fill_done = 1'b0;
    #3;
    chk(req_ready == 1'b1, "reset_ready", int'(req_ready), 1);
    chk(victim_valid == 1'b0, "reset_valid", int'(victim_valid), 0);
    chk(victim_onehot == 4'b0, "reset_onehot", int'(victim_onehot), 0);
    chk(lfsr_en == 1'b0, "reset_lfsr_en", int'(lfsr_en), 0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    do_miss(4'b1011, 4'b0000, 4'b0000, 8'h00, 0); finish_fill(1'b0);
    do_miss(4'b1111, 4'b0000, 4'b0000, 8'hA6, 0); finish_fill(1'b0);
    do_miss(4'b1111, 4'b0000, 4'b1000, 8'h03, 0); finish_fill(1'b0);
    do_miss(4'b1111, 4'b1111, 4'b1101, 8'h00, 3); finish_fill(1'b0);
    do_miss(4'b0110, 4'b0000, 4'b0001, 8'h55, 0); finish_fill(1'b1);
    do_miss(4'b1011, 4'b0000, 4'b0000, 8'h00, 0); finish_fill(1'b0);

    // Abort held across accept (no effect in IDLE) and through PICK.
    req_valid = 1'b1; way_valid = 4'b1111; way_lock = 4'b0000; abort = 1'b1;
    lfsr_out = 8'h01;
    #1;
    chk(req_ready == 1'b1, "abort_idle_ready", int'(req_ready), 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk(req_ready == 1'b0, "abort_idle_accept", int'(req_ready), 0);
    chk(lfsr_en == 1'b0, "abort_pick_lfsr_en", int'(lfsr_en), 0);
    @(posedge clk); #1;
    abort = 1'b0;
    chk(victim_valid == 1'b0, "abort_pick_valid", int'(victim_valid), 0);
    chk(req_ready == 1'b1, "abort_pick_ready", int'(req_ready), 1);

    // Asynchronous reset in HOLD with victim_way=2.
    do_miss(4'b1011, 4'b0000, 4'b0000, 8'h00, 0);
    #2;
    reset = 1'b0;
    #1;
    chk(victim_valid == 1'b0, "areset_valid", int'(victim_valid), 0);
    chk(victim_way == 2'd0, "areset_way", int'(victim_way), 0);
    chk(victim_onehot == 4'b0, "areset_onehot", int'(victim_onehot), 0);
    chk(lfsr_en == 1'b0, "areset_lfsr_en", int'(lfsr_en), 0);
    chk(req_ready == 1'b1, "areset_ready", int'(req_ready), 1);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk(victim_valid == 1'b0, "post_reset_valid", int'(victim_valid), 0);
    chk(req_ready == 1'b1, "post_reset_ready", int'(req_ready), 1);

    for (int t = 0; t < 30; t++) begin
      vm  = 4'($urandom_range(0, 15));
      clr = 4'b0001 << $urandom_range(0, 3);
      lk  = 4'($urandom_range(0, 15)) & ~clr;
      lf  = 8'($urandom_range(0, 255));
      st  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      do_miss(vm, 4'b1111, lk, lf, st);
      finish_fill($urandom_range(0, 4) == 0);
    end

    repeat (2) @(posedge clk);
    #1;
    chk(exp_q.size() == 0, "sb_leftover", exp_q.size(), 0);
    chk(en_seen == exp_en_cnt, "lfsr_en_pulses", en_seen, exp_en_cnt);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
